rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset sequencer between the bench/board clock-reset source and the MIPS pipeline core. It synchronizes the asynchronous active-low reset and holds the core in reset for a fixed number of cycles. It then drives a pipeline flush window before enabling PC fetch. It also services a software soft-reset request with a req/ack handshake, re-running the hold/flush sequence without touching the external reset.

Parameters:
SYNC_STAGES, 2, depth of reset-deassertion synchronizer chain (>=2)
HOLD_CYCLES, 16, cycles core_rst_n is held low after synchronized release (>=1)
FLUSH_CYCLES, 5, cycles pipe_flush is asserted, equal to pipeline depth (>=1)
CNT_W, 32, width of cycle_cnt

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
soft_rst_req  in  1  level request for soft reset, held until ack
soft_rst_ack  out  1  one-cycle pulse acknowledging soft_rst_req
core_rst_n  out  1  synchronous active-low reset to pipeline core
pipe_flush  out  1  high during flush window; pipeline registers load bubbles
pc_en  out  1  PC update/fetch enable
ready  out  1  core running
state_o  out  2  FSM state: 0 RESET, 1 HOLD, 2 FLUSH, 3 RUN
cycle_cnt  out  CNT_W  cycles spent in RUN since last HOLD entry

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- All outputs registered (Moore); every register clears asynchronously when rst=0.
- Reset values: state_o=0, core_rst_n=0, pipe_flush=0, pc_en=0, ready=0, soft_rst_ack=0, cycle_cnt=0.
- Sync chain: SYNC_STAGES flops, async clear to 0, shift in 1.
  - After rst rises, sync_n=1 following the SYNC_STAGES-th rising edge.
  - Assertion of rst is immediate (async), never synchronized.
- RESET: all outputs at reset values. At the first edge where sync_n==1 is sampled -> HOLD, counter=0.
- HOLD: core_rst_n=0, pc_en=0, pipe_flush=0, ready=0.
  - Stays exactly HOLD_CYCLES cycles, then -> FLUSH with counter=0.
  - cycle_cnt cleared on HOLD entry.
- FLUSH: core_rst_n=1, pipe_flush=1, pc_en=0, ready=0.
  - Stays exactly FLUSH_CYCLES cycles, then -> RUN.
- RUN: core_rst_n=1, pipe_flush=0, pc_en=1, ready=1.
  - cycle_cnt increments by 1 each cycle and saturates at all-ones (no wrap).
- Timing with defaults: RUN (ready=1) visible after edge SYNC_STAGES+1+HOLD_CYCLES+FLUSH_CYCLES = edge 24 counted from rst deassertion.
- Soft reset:
  - Only sampled in RUN. soft_rst_req=1 at an edge in RUN causes: soft_rst_ack=1 for that next cycle, state -> HOLD, and outputs take HOLD values in the same cycle.
  - Ack is a single pulse even if req stays high.
  - If req is still high when RUN is re-entered, it is acked again (requester must drop req on ack).
  - A req raised in RESET/HOLD/FLUSH is not acked until RUN is reached.
- rst low mid-sequence (any state): immediate return to reset values; the sequence restarts from the sync chain.
- Glitch on rst shorter than one cycle: still clears everything (async); full sequence re-runs.
- Hold/flush counters sized $clog2(max(HOLD_CYCLES,FLUSH_CYCLES)+1); terminal count compares to N-1.

Test Plan:
- Power-on: rst low 5 cycles, release -> state_o 0,0 then HOLD for 16 cycles, FLUSH for 5 with pipe_flush=1, ready=1 first seen after edge 24; core_rst_n rises exactly at FLUSH entry.
- Run counting: after ready, hold 100 cycles -> cycle_cnt=100; with CNT_W=4, run 20 cycles -> cycle_cnt saturates at 15.
- Soft reset: in RUN, pulse soft_rst_req until ack -> soft_rst_ack high exactly 1 cycle, next 16 cycles HOLD, 5 FLUSH, ready returns after 21 cycles, cycle_cnt restarts from 0.
- Held request: soft_rst_req held high for 50 cycles -> two acks, 22 cycles apart (21 cycles out of RUN plus the first RUN-cycle sample).
- Mid-sequence reset: assert rst during FLUSH cycle 3 -> pipe_flush and all outputs drop asynchronously; after release, the full 24-edge sequence is repeated.
- Early request: soft_rst_req=1 during HOLD after power-on -> no ack until RUN; ack on the cycle after RUN entry, then HOLD again.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the MIPS pipeline core: synchronizes the board reset, then runs a
// HOLD -> FLUSH -> RUN sequence that a software soft-reset request can re-trigger.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 16,
    parameter int FLUSH_CYCLES = 5,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst_req,
    output logic             soft_rst_ack,
    output logic             core_rst_n,
    output logic             pipe_flush,
    output logic             pc_en,
    output logic             ready,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int MAX_CYC = (HOLD_CYCLES > FLUSH_CYCLES) ? HOLD_CYCLES : FLUSH_CYCLES;
    localparam int PH_W    = $clog2(MAX_CYC + 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    // Release is synchronized through the chain; assertion bypasses it via the async clear.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic              ack_q, ack_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              pipe_flush_q, pipe_flush_d;
    logic              run_q, run_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        ack_d    = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                if (sync_n) begin
                    state_d  = ST_HOLD;
                    ph_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (ph_cnt_q == HOLD_LAST) begin
                    state_d  = ST_FLUSH;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_FLUSH: begin
                if (ph_cnt_q == FLUSH_LAST) begin
                    state_d  = ST_RUN;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_RUN: begin
                if (soft_rst_req) begin
                    state_d  = ST_HOLD;
                    ph_cnt_d = '0;
                    ack_d    = 1'b1;
                end
            end
            default: begin
                state_d  = ST_RESET;
                ph_cnt_d = '0;
            end
        endcase

        // RUN-cycle counter: zero throughout HOLD, saturating while running.
        run_cnt_d = run_cnt_q;
        if (state_d == ST_HOLD) begin
            run_cnt_d = '0;
        end else if (state_q == ST_RUN && run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end

        // Outputs decode the next state so the registered values line up with state_o.
        core_rst_n_d = (state_d == ST_FLUSH) || (state_d == ST_RUN);
        pipe_flush_d = (state_d == ST_FLUSH);
        run_d        = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RESET;
            ph_cnt_q     <= '0;
            run_cnt_q    <= '0;
            ack_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            pipe_flush_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_cnt_q     <= ph_cnt_d;
            run_cnt_q    <= run_cnt_d;
            ack_q        <= ack_d;
            core_rst_n_q <= core_rst_n_d;
            pipe_flush_q <= pipe_flush_d;
            run_q        <= run_d;
        end
    end

    assign state_o      = state_q;
    assign soft_rst_ack = ack_q;
    assign core_rst_n   = core_rst_n_q;
    assign pipe_flush   = pipe_flush_q;
    assign pc_en        = run_q;
    assign ready        = run_q;
    assign cycle_cnt    = run_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: directed scenarios plus random req/reset traffic,
// compared each cycle against a timeline model (cycles elapsed since HOLD entry).
module tb_rst_seq_ctrl;

    localparam int SYNC = 2;
    localparam int H    = 16;
    localparam int F    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0;

    logic        a_ack, a_crn, a_flush, a_pcen, a_ready;
    logic [1:0]  a_state;
    logic [31:0] a_cnt;
    logic        b_ack, b_crn, b_flush, b_pcen, b_ready;
    logic [1:0]  b_state;
    logic [3:0]  b_cnt;

    rst_seq_ctrl dut (
        .clk(clk), .rst(rst), .soft_rst_req(req),
        .soft_rst_ack(a_ack), .core_rst_n(a_crn), .pipe_flush(a_flush),
        .pc_en(a_pcen), .ready(a_ready), .state_o(a_state), .cycle_cnt(a_cnt)
    );

    rst_seq_ctrl #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .soft_rst_req(req),
        .soft_rst_ack(b_ack), .core_rst_n(b_crn), .pipe_flush(b_flush),
        .pc_en(b_pcen), .ready(b_ready), .state_o(b_state), .cycle_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: edges since release; once started, k = edges since the last HOLD entry.
    int m_e;
    bit m_started;
    int m_k;
    bit m_ack;

    function automatic int m_state();
        if (!m_started)  return 0;
        if (m_k < H)     return 1;
        if (m_k < H + F) return 2;
        return 3;
    endfunction

    function automatic longint m_cnt(input longint maxv);
        longint c;
        if (m_state() != 3) return 0;
        c = longint'(m_k - (H + F));
        return (c > maxv) ? maxv : c;
    endfunction

    task automatic m_reset();
        m_e = 0; m_started = 0; m_k = 0; m_ack = 0;
    endtask

    task automatic m_edge(input bit r);
        if (!rst) return;
        m_e++;
        m_ack = 0;
        if (!m_started) begin
            if (m_e >= SYNC + 1) begin
                m_started = 1;
                m_k = 0;
            end
        end else if (m_state() == 3 && r) begin
            m_ack = 1;
            m_k = 0;
        end else begin
            m_k++;
        end
    endtask

    task automatic check_all();
        int s;
        s = m_state();
        check("state",      64'(a_state), 64'(s));
        check("core_rst_n", 64'(a_crn),   64'(s >= 2));
        check("pipe_flush", 64'(a_flush), 64'(s == 2));
        check("pc_en",      64'(a_pcen),  64'(s == 3));
        check("ready",      64'(a_ready), 64'(s == 3));
        check("ack",        64'(a_ack),   64'(m_ack));
        check("cycle_cnt",  64'(a_cnt),   64'(m_cnt(64'hFFFF_FFFF)));
        check("w4_state",   64'(b_state), 64'(s));
        check("w4_ack",     64'(b_ack),   64'(m_ack));
        check("w4_cnt",     64'(b_cnt),   64'(m_cnt(15)));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            m_edge(req);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic assert_rst();
        rst = 1'b0;
        m_reset();
        #1;
        check_all();
    endtask

    task automatic glitch_rst();
        rst = 1'b0;
        m_reset();
        #1;
        check_all();
        #1;
        rst = 1'b1;
    endtask

    task automatic ready_latency(input string tag, input int exp);
        int n;
        n = 0;
        while (!a_ready && n < 60) begin
            cyc(1);
            n++;
        end
        check(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        int n, first, second;
        m_reset();
        @(negedge clk);
        check_all();

        // Power-on
        cyc(5);
        rst = 1'b1;
        ready_latency("poweron_ready_edge", 24);
        cyc(100);
        check("cnt_after_100", 64'(a_cnt), 64'd100);
        check("w4_saturated", 64'(b_cnt), 64'd15);

        // Soft reset pulse
        req = 1'b1;
        n = 0;
        while (!a_ack && n < 10) begin
            cyc(1);
            n++;
        end
        req = 1'b0;
        check("soft_ack_seen", 64'(a_ack), 64'd1);
        cyc(1);
        check("soft_ack_single", 64'(a_ack), 64'd0);
        ready_latency("soft_ready_latency", 20);
        check("soft_cnt_restart", 64'(a_cnt), 64'd0);

        // Held request
        cyc(3);
        first = -1;
        second = -1;
        req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (a_ack) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        req = 1'b0;
        check("held_ack_gap", 64'(second - first), 64'd22);
        cyc(30);

        // Mid-sequence reset during FLUSH cycle 3
        assert_rst();
        cyc(2);
        rst = 1'b1;
        n = 0;
        while (!(m_state() == 2 && m_k == H + 2) && n < 60) begin
            cyc(1);
            n++;
        end
        check("flush3_reached", 64'(a_flush), 64'd1);
        assert_rst();
        check("flush_async_drop", 64'(a_flush), 64'd0);
        cyc(3);
        rst = 1'b1;
        ready_latency("restart_ready_edge", 24);

        // Early request raised in HOLD
        assert_rst();
        cyc(2);
        rst = 1'b1;
        cyc(8);
        req = 1'b1;
        n = 0;
        while (!a_ack && n < 40) begin
            cyc(1);
            n++;
        end
        req = 1'b0;
        check("early_ack_latency", 64'(n), 64'd17);
        cyc(1);
        check("early_back_to_hold", 64'(a_state), 64'd1);
        cyc(25);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                glitch_rst();
            end else if (r < 4) begin
                assert_rst();
                cyc(int'($urandom_range(1, 4)));
                rst = 1'b1;
            end
            req = ($urandom_range(0, 24) == 0);
            cyc(1);
        end
        req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
